// File: rtl/div_unit_if.sv
// div_unit_if: execute-stage <-> divider request/result bundle.
// Latency: n/a (wires only); the divider registers every output it drives here.
// Backpressure: initiator holds start_i high until it has consumed result_o/ready_o.
// Ports: signed_div_i, opdata1_i, opdata2_i, start_i, annul_i (initiator -> divider);
//        result_o {rem, quot}, ready_o, and divzero_o when DIV_ZERO_FLAG_EN is defined.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
`ifdef DIV_ZERO_FLAG_EN
  logic               divzero_o;
`endif

  // Execute stage side.
  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
`ifdef DIV_ZERO_FLAG_EN
    input  divzero_o,
`endif
    input  result_o, ready_o
  );

  // Divider side.
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
`ifdef DIV_ZERO_FLAG_EN
    output divzero_o,
`endif
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider (DIV/DIVU) returning {remainder, quotient}.
// Latency: ready_o high after edge WIDTH+1 (edge 1 accepts start); zero divisor after edge 2.
// Backpressure: result and ready_o hold in END while start_i stays high; start_i low frees the unit.
// Ports: clk, rst (sync, active-high), bus (div_unit_if.slave): signed_div_i, opdata1_i,
//        opdata2_i, start_i, annul_i in; result_o [2W-1:W]=rem [W-1:0]=quot, ready_o out.
// Optional: define DIV_ZERO_FLAG_EN to add divzero_o, flagging results produced via ZERO.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  div_unit_if.slave    bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_FREE = 2'd0,
    S_ZERO = 2'd1,
    S_ON   = 2'd2,
    S_END  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  // {partial remainder, dividend, pad}: upper W+1 bits are the trial window.
  logic [2*WIDTH:0]     sr_q, sr_d;
  logic [WIDTH-1:0]     divisor_q, divisor_d;
  logic                 neg_quot_q, neg_quot_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;
  logic                 divzero_q, divzero_d;

  // Operand magnitudes and sign flags (only meaningful in FREE).
  logic                 op1_neg, op2_neg;
  logic [WIDTH-1:0]     op1_mag, op2_mag;

  // One restoring step.
  logic [WIDTH+1:0]     trial;
  logic [2*WIDTH:0]     sr_step;
  logic [WIDTH-1:0]     quot_raw, rem_raw, quot_fix, rem_fix;

  always_comb begin
    op1_neg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    op2_neg = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    op1_mag = op1_neg ? (~bus.opdata1_i + WIDTH'(1)) : bus.opdata1_i;
    op2_mag = op2_neg ? (~bus.opdata2_i + WIDTH'(1)) : bus.opdata2_i;

    // Extra top bit of the trial acts as the borrow: set means window < divisor.
    trial = {1'b0, sr_q[2*WIDTH:WIDTH]} - {2'b00, divisor_q};
    if (trial[WIDTH+1]) begin
      sr_step = {sr_q[2*WIDTH-1:0], 1'b0};
    end else begin
      // Window replaced by the difference (which fits in W bits), then shifted with a 1.
      sr_step = {trial[WIDTH-1:0], sr_q[WIDTH-1:0], 1'b1};
    end

    // After the last step the quotient bits fill the low W bits and the final
    // remainder has been shifted up one place above the pad bit.
    quot_raw = sr_step[WIDTH-1:0];
    rem_raw  = sr_step[2*WIDTH:WIDTH+1];
    quot_fix = neg_quot_q ? (~quot_raw + WIDTH'(1)) : quot_raw;
    rem_fix  = neg_rem_q  ? (~rem_raw  + WIDTH'(1)) : rem_raw;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;
    divzero_d  = divzero_q;

    unique case (state_q)
      S_FREE: begin
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_d = S_ZERO;
          end else begin
            state_d    = S_ON;
            cnt_d      = '0;
            sr_d       = {{WIDTH{1'b0}}, op1_mag, 1'b0};
            divisor_d  = op2_mag;
            neg_quot_d = op1_neg ^ op2_neg;
            neg_rem_d  = op1_neg;
          end
        end
      end

      S_ZERO: begin
        if (bus.annul_i) begin
          state_d = S_FREE;
        end else begin
          state_d   = S_END;
          result_d  = '0;
          ready_d   = 1'b1;
          divzero_d = 1'b1;
        end
      end

      S_ON: begin
        if (bus.annul_i) begin
          state_d = S_FREE;
          cnt_d   = '0;
        end else begin
          sr_d  = sr_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            state_d  = S_END;
            result_d = {rem_fix, quot_fix};
            ready_d  = 1'b1;
          end
        end
      end

      S_END: begin
        // annul_i is deliberately ignored here: the result is already committed.
        if (!bus.start_i) begin
          state_d   = S_FREE;
          cnt_d     = '0;
          result_d  = '0;
          ready_d   = 1'b0;
          divzero_d = 1'b0;
        end
      end

      default: begin
        state_d = S_FREE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FREE;
      cnt_q      <= '0;
      sr_q       <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
      divzero_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
      divzero_q  <= divzero_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

`ifdef DIV_ZERO_FLAG_EN
  assign bus.divzero_o = divzero_q;
`else
  // Without the flag output a divide-by-zero reads as an ordinary zero result.
  logic unused_divzero;
  assign unused_divzero = divzero_q;
`endif

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed-vector bench for div_unit with hand-computed results.
// Latency: checks ready_o edge count from start acceptance (33 normal, 2 for zero divisor).
// Backpressure: holds start_i through END, then drops it and checks the outputs clear.
module tb_div_unit;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start an operation, scramble operands after acceptance, and check latency/result.
  // start_i is left high so the caller controls the END hold.
  task automatic run_op(input string tag, input logic sd, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
    int n;
    bus.signed_div_i = sd;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    n = 0;
    do begin
      step();
      n++;
      if (n == 1) begin
        bus.signed_div_i = ~sd;
        bus.opdata1_i    = ~a;
        bus.opdata2_i    = b ^ 32'h5A5A_0001;
      end
    end while (!bus.ready_o && n < 100);
    chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
    chk({tag, "_res"}, bus.result_o, exp_res);
  endtask

  task automatic release_op(input string tag);
    bus.start_i = 1'b0;
    step();
    chk({tag, "_rdy_clr"}, 64'(bus.ready_o), 64'd0);
    chk({tag, "_res_clr"}, bus.result_o, 64'd0);
  endtask

  initial begin
    int seen;
    tests_run        = 0;
    tests_failed     = 0;
    rst              = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (3) step();
    chk("reset_rdy", 64'(bus.ready_o), 64'd0);
    chk("reset_res", bus.result_o, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
    chk("reset_dz", 64'(bus.divzero_o), 64'd0);
`endif
    rst = 1'b0;
    step();

    // Unsigned 100 / 7 = 14 r 2.
    run_op("u100_7", 1'b0, 32'd100, 32'd7, 33, {32'h0000_0002, 32'h0000_000E});
    release_op("u100_7");
    step();

    // Signed -7 / 2 = -3 r -1.
    run_op("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    release_op("s-7_2");
    step();

    // Signed 7 / -2 = -3 r 1.
    run_op("s7_-2", 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 33, {32'h0000_0001, 32'hFFFF_FFFD});
    release_op("s7_-2");
    step();

    // Unsigned mode never negates: 0xFFFFFFF9 / 2 = 0x7FFFFFFC r 1.
    run_op("u_big_2", 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 33, {32'h0000_0001, 32'h7FFF_FFFC});
    release_op("u_big_2");
    step();

    // Divide by zero.
    run_op("div0", 1'b0, 32'h1234_5678, 32'h0, 2, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
    chk("div0_dz_set", 64'(bus.divzero_o), 64'd1);
`endif
    release_op("div0");
`ifdef DIV_ZERO_FLAG_EN
    chk("div0_dz_clr", 64'(bus.divzero_o), 64'd0);
`endif
    step();

    // Annul at edge 10 of ON: no result may ever appear.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    seen = 0;
    repeat (10) begin
      step();
      if (bus.ready_o) seen++;
    end
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    step();
    bus.annul_i = 1'b0;
    repeat (40) begin
      step();
      if (bus.ready_o) seen++;
    end
    chk("annul_no_rdy", 64'(seen), 64'd0);
    chk("annul_res", bus.result_o, 64'd0);

    run_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 33, {32'h0000_0000, 32'hFFFF_FFFF});
    release_op("u_max_1");
    step();

    // Signed overflow, then hold in END with annul and operand noise.
    run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h0000_0000, 32'h8000_0000});
    seen = 0;
    bus.annul_i   = 1'b1;
    bus.opdata2_i = 32'h0;
    repeat (5) begin
      step();
      if (!bus.ready_o || bus.result_o !== {32'h0000_0000, 32'h8000_0000}) seen++;
    end
    chk("s_ovf_hold", 64'(seen), 64'd0);
    bus.annul_i = 1'b0;
    release_op("s_ovf");
    step();

    // Reset at edge 20 of an operation.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd5000;
    bus.opdata2_i    = 32'd9;
    bus.start_i      = 1'b1;
    repeat (19) step();
    rst         = 1'b1;
    bus.start_i = 1'b0;
    step();
    chk("rst_mid_rdy", 64'(bus.ready_o), 64'd0);
    chk("rst_mid_res", bus.result_o, 64'd0);
    rst = 1'b0;
    step();
    run_op("after_rst", 1'b0, 32'h1234_5678, 32'h0000_0010, 33, {32'h0000_0008, 32'h0123_4567});
    release_op("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
